// File: rtl/forwarding_scoreboard_pkg.sv
// forwarding_scoreboard_pkg: shared types and constants for the forwarding scoreboard.
//   scoreboard_entry_t : one in-flight instruction (valid, rd, we, ready_stage)
//   FwdFromRegFile     : forward_sel value meaning "read the register file"
//   ReadyAtEx/ReadyAtMem : ready_stage encodings for ALU results and loads
// Entry fields are sized to fixed maxima so the struct can live in the package;
// parameterised widths in the modules are zero-extended into them.
package forwarding_scoreboard_pkg;

  localparam int unsigned MaxRegAddrWidth = 8;
  localparam int unsigned MaxSelWidth     = 4;

  localparam int unsigned FwdFromRegFile = 0;
  localparam int unsigned ReadyAtEx      = 0;
  localparam int unsigned ReadyAtMem     = 1;

  typedef struct packed {
    logic                       valid;
    logic [MaxRegAddrWidth-1:0] rd;
    logic                       we;
    logic [MaxSelWidth-1:0]     ready_stage;
  } scoreboard_entry_t;

endpackage

// File: rtl/forwarding_scoreboard_match.sv
// scoreboard_match: forwarding select and hazard for one decode read port.
//   entries : in-flight entry array, index 0 = youngest (EX)
//   rs_addr : source register of this port
//   rs_used : source is actually read
//   sel     : 0 = register file, k+1 = entry k supplies the operand
//   hazard  : youngest matching producer has not reached its ready stage
module scoreboard_match
  import forwarding_scoreboard_pkg::*;
#(
  parameter int unsigned PIPE_DEPTH     = 3,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned SEL_WIDTH      = 2
) (
  input  scoreboard_entry_t [PIPE_DEPTH-1:0] entries,
  input  logic [REG_ADDR_WIDTH-1:0]          rs_addr,
  input  logic                               rs_used,
  output logic [SEL_WIDTH-1:0]               sel,
  output logic                               hazard
);

  logic found;

  // Youngest-first scan: the first hit is latched via 'found'.
  always_comb begin
    sel    = SEL_WIDTH'(FwdFromRegFile);
    hazard = 1'b0;
    found  = 1'b0;
    for (int unsigned k = 0; k < PIPE_DEPTH; k++) begin
      if (!found && rs_used && entries[k].valid && entries[k].we &&
          (entries[k].rd != '0) &&
          (entries[k].rd == MaxRegAddrWidth'(rs_addr))) begin
        found  = 1'b1;
        sel    = SEL_WIDTH'(k + 1);
        hazard = (k < 32'(entries[k].ready_stage));
      end
    end
  end

endmodule

// File: rtl/forwarding_scoreboard.sv
// forwarding_scoreboard: tracks in-flight destination registers after decode and
// produces per-port forwarding selects plus a load-use hazard stall.
//   clock, reset      : single clock, synchronous active-high reset
//   issue_*           : instruction leaving decode this cycle
//   rs_addr, rs_used  : decode source registers
//   stall_in, flush   : external freeze; squash of decode + EX entry
//   forward_sel       : per-port operand mux select (combinational)
//   hazard_stall      : decode must hold (combinational)
//   stall_cycles      : hazard stall counter, present only when
//                       FORWARDING_SCOREBOARD_PERF_EN is defined
module forwarding_scoreboard
  import forwarding_scoreboard_pkg::*;
#(
  parameter  int unsigned PIPE_DEPTH     = 3,
  parameter  int unsigned NUM_READ_PORTS = 2,
  parameter  int unsigned REG_ADDR_WIDTH = 5,
  localparam int unsigned SEL_WIDTH      = $clog2(PIPE_DEPTH + 1)
) (
  input  logic                                           clock,
  input  logic                                           reset,
  input  logic                                           issue_valid,
  input  logic [REG_ADDR_WIDTH-1:0]                      issue_rd,
  input  logic                                           issue_we,
  input  logic [SEL_WIDTH-1:0]                           issue_ready_stage,
  input  logic [NUM_READ_PORTS-1:0][REG_ADDR_WIDTH-1:0]  rs_addr,
  input  logic [NUM_READ_PORTS-1:0]                      rs_used,
  input  logic                                           stall_in,
  input  logic                                           flush,
  output logic [NUM_READ_PORTS-1:0][SEL_WIDTH-1:0]       forward_sel,
  output logic                                           hazard_stall
`ifdef FORWARDING_SCOREBOARD_PERF_EN
  ,
  output logic [31:0]                                    stall_cycles
`endif
);

  scoreboard_entry_t [PIPE_DEPTH-1:0] entries_q, entries_d;
  logic [NUM_READ_PORTS-1:0]          port_hazard;

  for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_port
    scoreboard_match #(
      .PIPE_DEPTH     (PIPE_DEPTH),
      .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
      .SEL_WIDTH      (SEL_WIDTH)
    ) u_match (
      .entries (entries_q),
      .rs_addr (rs_addr[p]),
      .rs_used (rs_used[p]),
      .sel     (forward_sel[p]),
      .hazard  (port_hazard[p])
    );
  end

  assign hazard_stall = |port_hazard;

  // Flush overrides both the shift (EX entry dropped, not moved to MEM) and
  // stall_in (entry 0 cleared even while frozen).
  always_comb begin
    entries_d = entries_q;
    if (!stall_in) begin
      for (int unsigned k = 1; k < PIPE_DEPTH; k++) begin
        entries_d[k] = (k == 1 && flush) ? '0 : entries_q[k-1];
      end
      entries_d[0] = '0;
      if (issue_valid && !hazard_stall && !flush) begin
        entries_d[0].valid       = 1'b1;
        entries_d[0].rd          = MaxRegAddrWidth'(issue_rd);
        entries_d[0].we          = issue_we;
        entries_d[0].ready_stage = MaxSelWidth'(issue_ready_stage);
      end
    end
    if (flush) begin
      entries_d[0] = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      entries_q <= '0;
    end else begin
      entries_q <= entries_d;
    end
  end

`ifdef FORWARDING_SCOREBOARD_PERF_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (hazard_stall && !stall_in && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cycles_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
`endif

  ready_stage_legal: assert property (@(posedge clock) disable iff (reset)
    issue_valid |-> (32'(issue_ready_stage) < PIPE_DEPTH));

endmodule

// File: tb/tb_forwarding_scoreboard.sv
module tb_forwarding_scoreboard;

  localparam int DEPTH = 3;

  logic            clock = 1'b0;
  logic            reset;
  logic            issue_valid;
  logic [4:0]      issue_rd;
  logic            issue_we;
  logic [1:0]      issue_ready_stage;
  logic [1:0][4:0] rs_addr;
  logic [1:0]      rs_used;
  logic            stall_in;
  logic            flush;
  logic [1:0][1:0] forward_sel;
  logic            hazard_stall;
`ifdef FORWARDING_SCOREBOARD_PERF_EN
  logic [31:0]     stall_cycles;
`endif

  int n_cmp = 0;
  int n_err = 0;

  forwarding_scoreboard #(
    .PIPE_DEPTH     (3),
    .NUM_READ_PORTS (2),
    .REG_ADDR_WIDTH (5)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .issue_valid       (issue_valid),
    .issue_rd          (issue_rd),
    .issue_we          (issue_we),
    .issue_ready_stage (issue_ready_stage),
    .rs_addr           (rs_addr),
    .rs_used           (rs_used),
    .stall_in          (stall_in),
    .flush             (flush),
    .forward_sel       (forward_sel),
    .hazard_stall      (hazard_stall)
`ifdef FORWARDING_SCOREBOARD_PERF_EN
    ,
    .stall_cycles      (stall_cycles)
`endif
  );

  always #5 clock = ~clock;

  // Reference model: list of in-flight instructions, each with its age in stages.
  typedef struct {
    int rd;
    bit we;
    int rdy;
    int stage;
  } rec_t;

  rec_t         inflight[$];
  longint       exp_stall = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_port(input int rs, input bit used, output int sel, output bit haz);
    int best = -1;
    int best_rdy = 0;
    sel = 0;
    haz = 0;
    foreach (inflight[i]) begin
      if (used && inflight[i].we && inflight[i].rd != 0 && inflight[i].rd == rs &&
          (best < 0 || inflight[i].stage < best)) begin
        best     = inflight[i].stage;
        best_rdy = inflight[i].rdy;
      end
    end
    if (best >= 0) begin
      sel = best + 1;
      haz = (best < best_rdy);
    end
  endfunction

  task automatic model_update(input bit haz);
    if (reset) begin
      inflight.delete();
      exp_stall = 0;
      return;
    end
    if (haz && !stall_in) exp_stall++;
    if (flush) begin
      for (int i = inflight.size() - 1; i >= 0; i--)
        if (inflight[i].stage == 0) inflight.delete(i);
    end
    if (!stall_in) begin
      foreach (inflight[i]) inflight[i].stage++;
      for (int i = inflight.size() - 1; i >= 0; i--)
        if (inflight[i].stage >= DEPTH) inflight.delete(i);
      if (issue_valid && !haz && !flush)
        inflight.push_back('{rd: int'(issue_rd), we: issue_we, rdy: int'(issue_ready_stage), stage: 0});
    end
  endtask

  task automatic drive(input bit rst, input bit iv, input int rd, input bit we, input int rdy,
                       input int rs0, input bit u0, input int rs1, input bit u1,
                       input bit st, input bit fl);
    reset             = rst;
    issue_valid       = iv;
    issue_rd          = 5'(rd);
    issue_we          = we;
    issue_ready_stage = 2'(rdy);
    rs_addr[0]        = 5'(rs0);
    rs_addr[1]        = 5'(rs1);
    rs_used           = {u1, u0};
    stall_in          = st;
    flush             = fl;
    #1;
  endtask

  task automatic step();
    int s0, s1;
    bit h0, h1, haz;
    #1;
    model_port(int'(rs_addr[0]), rs_used[0], s0, h0);
    model_port(int'(rs_addr[1]), rs_used[1], s1, h1);
    haz = h0 | h1;
    chk("model_sel0", 32'(forward_sel[0]), 32'(s0));
    chk("model_sel1", 32'(forward_sel[1]), 32'(s1));
    chk("model_hazard", 32'(hazard_stall), 32'(haz));
`ifdef FORWARDING_SCOREBOARD_PERF_EN
    chk("model_stall_cycles", stall_cycles, 32'(exp_stall));
`endif
    @(posedge clock);
    model_update(haz);
    #1;
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clock);
    #1;
    step();
    drive(0, 0, 0, 0, 0, 5, 1, 5, 1, 0, 0);
    chk("reset_sel0", 32'(forward_sel[0]), 32'd0);
    chk("reset_hazard", 32'(hazard_stall), 32'd0);
    step();

    // ALU result walks down the pipe
    drive(0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    step();
    for (int i = 1; i <= 4; i++) begin
      drive(0, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0);
      chk($sformatf("alu_sel_%0d", i), 32'(forward_sel[0]), (i == 4) ? 32'd0 : 32'(i));
      chk($sformatf("alu_haz_%0d", i), 32'(hazard_stall), 32'd0);
      step();
    end

    // Load-use stall on port 1
    drive(0, 1, 7, 1, 1, 0, 0, 0, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 7, 1, 0, 0);
    chk("load_haz", 32'(hazard_stall), 32'd1);
    chk("load_sel", 32'(forward_sel[1]), 32'd1);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 7, 1, 0, 0);
    chk("load_haz_clear", 32'(hazard_stall), 32'd0);
    chk("load_sel2", 32'(forward_sel[1]), 32'd2);
    step();

    // rd=0 never forwards; unused source never forwards
    drive(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    chk("rd0_sel", 32'(forward_sel[0]), 32'd0);
    chk("rd0_haz", 32'(hazard_stall), 32'd0);
    step();
    drive(0, 1, 6, 1, 1, 0, 0, 0, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 6, 0, 6, 0, 0, 0);
    chk("unused_sel0", 32'(forward_sel[0]), 32'd0);
    chk("unused_haz", 32'(hazard_stall), 32'd0);
    step();

    // Youngest producer wins
    drive(0, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
    step();
    drive(0, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0);
    chk("youngest_sel", 32'(forward_sel[0]), 32'd1);
    step();

    // External stall holds the hazard
    drive(0, 1, 9, 1, 1, 0, 0, 0, 0, 0, 0);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 9, 1, 0, 0, 1, 0);
      chk("stall_sel", 32'(forward_sel[0]), 32'd1);
      chk("stall_haz", 32'(hazard_stall), 32'd1);
      step();
    end
    drive(0, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0);
    chk("release_haz", 32'(hazard_stall), 32'd1);
    step();
    drive(0, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0);
    chk("release_sel", 32'(forward_sel[0]), 32'd2);
    chk("release_haz_clear", 32'(hazard_stall), 32'd0);
    step();

    // Flush beats issue; reset clears an issued entry
    drive(0, 1, 4, 1, 0, 0, 0, 0, 0, 0, 1);
    step();
    drive(0, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0);
    chk("flush_sel", 32'(forward_sel[0]), 32'd0);
    step();
    drive(0, 1, 4, 1, 0, 0, 0, 0, 0, 0, 0);
    step();
    drive(1, 1, 8, 1, 0, 4, 1, 0, 0, 1, 1);
    step();
    drive(0, 0, 0, 0, 0, 4, 1, 8, 1, 0, 0);
    chk("reset_clear_sel0", 32'(forward_sel[0]), 32'd0);
    chk("reset_clear_sel1", 32'(forward_sel[1]), 32'd0);
    step();

    // Five hazard cycles after a reset
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 10, 1, 1, 0, 0, 0, 0, 0, 0);
      step();
      drive(0, 0, 0, 0, 0, 10, 1, 0, 0, 0, 0);
      step();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step();
    end
`ifdef FORWARDING_SCOREBOARD_PERF_EN
    chk("perf_five", stall_cycles, 32'd5);
`endif

    // Randomised traffic against the model
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 99) < 2, $urandom_range(0, 9) < 7, $urandom_range(0, 7),
            $urandom_range(0, 7) != 0, $urandom_range(0, 2),
            $urandom_range(0, 7), $urandom_range(0, 5) != 0,
            $urandom_range(0, 7), $urandom_range(0, 5) != 0,
            $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 10);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/forwarding_scoreboard.md
# forwarding_scoreboard

Parametrised successor to the combinational forwarding unit. It keeps an internal shift pipeline of in-flight destination registers, so the EX/MEM/WB rd and write-enable signals no longer come in as separate ports. For every decode read port it produces a forwarding select, and it raises a load-use hazard stall when the youngest matching producer has not yet produced its result. It sits beside the decode stage and drives the operand muxes and the decode/issue stall logic.

## Interface
- PIPE_DEPTH, 3, in-flight stages tracked after decode (0=EX, 1=MEM, 2=WB)
- NUM_READ_PORTS, 2, decode register read ports
- REG_ADDR_WIDTH, 5, register address width
- SEL_WIDTH, $clog2(PIPE_DEPTH+1), forwarding select width (derived, not overridden)
- clock  in  1  system clock; one clock domain
- reset  in  1  synchronous, active-high reset
- issue_valid  in  1  decode instruction issues this cycle
- issue_rd  in  REG_ADDR_WIDTH  destination of issuing instruction
- issue_we  in  1  issuing instruction writes rd
- issue_ready_stage  in  SEL_WIDTH  first stage whose register holds the result (0=ALU, 1=load)
- rs_addr  in  [NUM_READ_PORTS][REG_ADDR_WIDTH]  decode source registers
- rs_used  in  [NUM_READ_PORTS]  source is actually read
- stall_in  in  1  external pipeline freeze
- flush  in  1  squash the decode instruction and the EX entry
- forward_sel  out  [NUM_READ_PORTS][SEL_WIDTH]  0 = register file; k = stage k-1 result
- hazard_stall  out  1  decode must hold; bubble inserted
- stall_cycles  out  32  hazard stall counter (only with FORWARDING_SCOREBOARD_PERF_EN)

## Operation
- Entry[k] fields: valid, rd, we, ready_stage. Entry k matches port p when valid && we && rd != 0 && rd == rs_addr[p] && rs_used[p].
- Priority: the lowest k (youngest) match wins. forward_sel[p] = k+1, or 0 if no entry matches.
- Port hazard: the youngest match has k < ready_stage. hazard_stall = OR over ports. On a hazard port, forward_sel still reports the match.
- Update when stall_in=1: all entries hold; hazard_stall is still computed.
- Update when stall_in=0: entry[k+1] <= entry[k]; entry[PIPE_DEPTH-1] retires.
- Entry[0] loads the issue when issue_valid && !hazard_stall && !flush. Otherwise entry[0] becomes an invalid bubble.
- flush: entry[0] is cleared, entry[0] does not shift into entry[1] this cycle, and no issue is recorded. Flush beats issue, and flush beats stall_in for entry[0].
- forward_sel and hazard_stall are combinational from state and inputs; there is no output register.

## Timing
- Reset (synchronous): all entries invalid, forward_sel=0, hazard_stall=0, stall_cycles=0.
- Reset during any activity wins over issue, stall_in and flush in the same cycle.
- An ALU result (ready_stage 0) issued in cycle N is forwardable in cycle N+1 with sel=1, then sel=2 in N+2, sel=3 in N+3, and sel=0 from N+4.
- A load (ready_stage 1) issued in cycle N stalls a dependent in N+1. With no stall_in, the dependent sees sel=2 with hazard_stall=0 in N+2.
- stall_in together with hazard_stall: the entries hold and no bubble is inserted.
- A ready_stage >= PIPE_DEPTH is illegal; an assertion flags it.

## Configuration
- FORWARDING_SCOREBOARD_PERF_EN defined: stall_cycles counts cycles where hazard_stall && !stall_in && !reset. It saturates at 32'hFFFF_FFFF.
- FORWARDING_SCOREBOARD_PERF_EN undefined: neither the stall_cycles port nor the counter exists.

## Structure
- forwarding_scoreboard_pkg holds:
  - scoreboard_entry_t struct (valid, rd, we, ready_stage)
  - constants FwdFromRegFile=0, ReadyAtEx=0, ReadyAtMem=1
- Sub-module scoreboard_match: one per read port, instantiated NUM_READ_PORTS times. Inputs are the entry array and one rs; outputs are sel and hazard via youngest-first priority.

## Test plan
- Issue rd=5, ready 0; next cycles rs_addr[0]=5, used -> forward_sel[0] = 1, 2, 3, then 0; hazard_stall=0 throughout.
- Issue load rd=7, ready 1; next cycle rs_addr[1]=7 -> hazard_stall=1, sel=1. Following cycle -> hazard_stall=0, sel=2.
- Issue rd=0 with we=1, then rs=0 -> sel=0, no stall. Also rs matches but rs_used=0 -> sel=0, no stall.
- Issue rd=3 twice in back-to-back cycles, then rs=3 -> sel=1 (youngest entry).
- Load rd=9 then hold stall_in=1 for 3 cycles with rs=9 -> sel=1 and hazard_stall=1 held constant. Release -> sel=2 next cycle.
- Issue rd=4 with flush=1 -> rs=4 gives sel=0. Issue rd=4 then reset -> rs=4 gives sel=0. With PERF_EN, 5 hazard cycles -> stall_cycles=5.
